conv3x3_mac_sequencer: RTL

Sequences one shared 8x8 signed-coefficient Vedic multiplier (vedic_multiplier_8bit_convention) over a 3x3 convolution window. It accepts nine unsigned pixels plus nine signed kernel coefficients per window and issues one tap per clock into the multiplier. Products are accumulated into a signed sum, and the block emits the raw sum plus a shifted, clamped 8-bit output pixel. It sits between the line-buffer/window generator and the output image writer.

---
 rtl/conv3x3_mac_sequencer_if.sv | 28 ++
 rtl/conv3x3_mac_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac_sequencer_if.sv
// Window-in / result-out bundle for the 3x3 convolution MAC sequencer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the window side, out_valid/out_ready on the result side.
interface conv3x3_mac_sequencer_if #(
    parameter int ACC_W = 20
);
    logic                    in_valid;
    logic                    in_ready;
    logic [71:0]             win_pix;
    logic [71:0]             win_coef;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc_out;
    logic [7:0]              pix_out;
    logic                    busy;

    // Window source / result sink side
    modport master (
        output in_valid, win_pix, win_coef, out_ready,
        input  in_ready, out_valid, acc_out, pix_out, busy
    );

    // Sequencer side
    modport slave (
        input  in_valid, win_pix, win_coef, out_ready,
        output in_ready, out_valid, acc_out, pix_out, busy
    );
endinterface

// File: rtl/conv3x3_mac_sequencer.sv
// 3x3 convolution: nine pixel x coefficient taps through one shared 8x8 multiplier, summed and clamped.
// Latency: result valid 10 edges after the accepting edge; one window per 12 clocks with out_ready high.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, new windows ignored meanwhile.
module conv3x3_mac_sequencer #(
    parameter int ACC_W = 20,
    parameter int SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    conv3x3_mac_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [3:0]              tap;
    logic [71:0]             pix_q;
    logic [71:0]             coef_q;
    logic signed [15:0]      prod_q;
    logic signed [15:0]      prod_c;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_add;
    logic signed [ACC_W-1:0] acc_sh;
    logic [71:0]             pix_sh;
    logic [71:0]             coef_sh;
    logic [7:0]              tap_pix;
    logic [7:0]              tap_coef;
    logic [7:0]              clamp_c;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;

    // Unsigned pixel times signed coefficient, sign-magnitude Vedic style:
    // the coefficient magnitude (0x80 stays 0x80 for -128) is split into
    // nibbles, the four 4x4 cross products are combined, then the sign is
    // re-applied. Magnitude never exceeds 255*128, so 16 bits suffice.
    function automatic logic signed [15:0] vedic_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  mag;
        logic [7:0]  ll, lh, hl, hh;
        logic [15:0] u;
        mag = b[7] ? (~b + 8'd1) : b;
        ll  = {4'b0, a[3:0]} * {4'b0, mag[3:0]};
        lh  = {4'b0, a[3:0]} * {4'b0, mag[7:4]};
        hl  = {4'b0, a[7:4]} * {4'b0, mag[3:0]};
        hh  = {4'b0, a[7:4]} * {4'b0, mag[7:4]};
        u   = {8'b0, ll} + ({8'b0, lh} << 4) + ({8'b0, hl} << 4) + ({8'b0, hh} << 8);
        return b[7] ? $signed(~u + 16'd1) : $signed(u);
    endfunction

    // Operand select for the current tap and the shared multiplier
    always_comb begin
        pix_sh   = pix_q >> {tap, 3'b000};
        coef_sh  = coef_q >> {tap, 3'b000};
        tap_pix  = pix_sh[7:0];
        tap_coef = coef_sh[7:0];
        prod_c   = vedic_mul8(tap_pix, tap_coef);
    end

    // Accumulator next value: previous cycle's registered product, sign-extended
    always_comb begin
        acc_add = acc + {{(ACC_W-16){prod_q[15]}}, prod_q};
    end

    // Scale and clamp the finished sum to an 8-bit pixel
    always_comb begin
        acc_sh = acc >>> SHIFT;
        if (acc_sh[ACC_W-1]) begin
            clamp_c = 8'd0;
        end else if (|acc_sh[ACC_W-2:8]) begin
            clamp_c = 8'd255;
        end else begin
            clamp_c = acc_sh[7:0];
        end
    end

    // Sequencer: capture window, run nine taps, drain the pipeline, hold the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tap         <= 4'd0;
            acc         <= '0;
            prod_q      <= '0;
            pix_q       <= '0;
            coef_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pix_q      <= bus.win_pix;
                        coef_q     <= bus.win_coef;
                        acc        <= '0;
                        prod_q     <= '0;
                        tap        <= 4'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    prod_q <= prod_c;
                    acc    <= acc_add;
                    if (tap == 4'd8) begin
                        tap   <= 4'd0;
                        state <= DRAIN;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                DRAIN: begin
                    acc         <= acc_add;
                    prod_q      <= '0;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.acc_out   = out_valid_q ? acc : '0;
    assign bus.pix_out   = out_valid_q ? clamp_c : 8'd0;
endmodule
